instr_fsm: RTL and testbench

INSTR_FSM -- requirements
Module: instr_fsm

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/instr_dec.sv | 18 +
 rtl/instr_fsm.sv | 117 +++++++++++
 tb/tb_instr_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction controller: FSM states, opcode/op
// encodings, write-back select values and the decoded instruction fields.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_IMM = 3'd5,
        S_WR_REG = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } instr_fields_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_dec.sv
// Pure combinational field extraction for the latched instruction word.
module instr_dec
    import ctrl_pkg::*;
(
    input  logic [15:0]   ir,
    output instr_fields_t fields,
    output logic [15:0]   sximm8
);

    assign fields.opcode = ir[15:13];
    assign fields.op     = ir[12:11];
    assign fields.rn     = ir[10:8];
    assign fields.rd     = ir[7:5];
    assign fields.sh     = ir[4:3];
    assign fields.rm     = ir[2:0];
    assign sximm8        = sext8(ir[7:0]);

endmodule

// File: rtl/instr_fsm.sv
// Multi-cycle controller: latches an instruction on start, then sequences the
// register-file reads, ALU execute and write-back with Moore-decoded controls.
module instr_fsm
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8
);

    state_e        state_q, state_d;
    logic [15:0]   ir_q;
    instr_fields_t f;
    logic          is_alu;

    instr_dec u_dec (
        .ir     (ir_q),
        .fields (f),
        .sximm8 (sximm8)
    );

    assign is_alu = (f.opcode == OPC_ALU);
    assign bsel   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            // Only captured on accept, so instr may change freely while busy.
            if (state_q == S_WAIT && s)
                ir_q <= instr;
        end
    end

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = VSEL_C;
        shift    = 2'b00;
        aluop    = 2'b00;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (f.opcode == OPC_MOV && f.op == OP_MOVI)
                    state_d = S_WR_IMM;
                else if (f.opcode == OPC_MOV && f.op == OP_MOVR)
                    state_d = S_GET_B;
                else if (is_alu)
                    state_d = (f.op == OP_MVN) ? S_GET_B : S_GET_A;
                else
                    state_d = S_WAIT;
            end
            S_GET_A: begin
                readnum = f.rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = f.rm;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                loadc   = 1'b1;
                shift   = f.sh;
                aluop   = is_alu ? f.op : OP_ADD;
                // MOV-reg and MVN are single-operand: zero the A input.
                asel    = !is_alu || (f.op == OP_MVN);
                loads   = is_alu && (f.op == OP_CMP);
                state_d = (is_alu && f.op == OP_CMP) ? S_WAIT : S_WR_REG;
            end
            S_WR_IMM: begin
                write    = 1'b1;
                writenum = f.rn;
                vsel     = VSEL_IMM;
                state_d  = S_WAIT;
            end
            S_WR_REG: begin
                write    = 1'b1;
                writenum = f.rd;
                vsel     = VSEL_C;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_instr_fsm.sv
// Scoreboard bench: each issued instruction pushes its per-cycle expected
// control snapshots; a negedge monitor pops and compares them.
module tb_instr_fsm;

    typedef struct packed {
        logic        w;
        logic [2:0]  rn;
        logic [2:0]  wn;
        logic [7:0]  ctl;   // write loada loadb loadc loads asel bsel vsel
        logic [1:0]  sh;
        logic [1:0]  alu;
        logic [15:0] sx;
    } snap_t;

    logic        clk, rst_n, s;
    logic [15:0] instr;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;
    snap_t expq[$];
    string tagq[$];
    snap_t stage[$];
    snap_t got;

    instr_fsm dut (
        .clk(clk), .rst_n(rst_n), .s(s), .instr(instr), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift),
        .aluop(aluop), .sximm8(sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = '{w: w, rn: readnum, wn: writenum,
                   ctl: {write, loada, loadb, loadc, loads, asel, bsel, vsel},
                   sh: shift, alu: aluop, sx: sximm8};

    function automatic snap_t S(input logic wv, input logic [2:0] rn,
                                input logic [2:0] wn, input logic [7:0] ctl,
                                input logic [1:0] sh, input logic [1:0] alu,
                                input logic [15:0] sx);
        snap_t r;
        r.w = wv; r.rn = rn; r.wn = wn; r.ctl = ctl;
        r.sh = sh; r.alu = alu; r.sx = sx;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (expq.size() > 0) begin
                snap_t e;
                string t;
                e = expq.pop_front();
                t = tagq.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h", t, got, e);
                end
            end else begin
                checks++;
                if ({w, write, loada, loadb, loadc, loads} !== 6'b100000) begin
                    errors++;
                    $display("FAIL idle got=%b exp=100000",
                             {w, write, loada, loadb, loadc, loads});
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] g, input logic [15:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    // Staged snapshots are queued only after the accept edge so the monitor
    // never matches them against the preceding idle cycle.
    task automatic issue(input logic [15:0] ins, input string nm,
                         input bit noise, input bit nosync);
        int n;
        n = stage.size() - 1;
        if (!nosync) @(negedge clk);
        instr = ins;
        s = 1'b1;
        @(posedge clk);
        #1;
        s = 1'b0;
        foreach (stage[i]) begin
            expq.push_back(stage[i]);
            tagq.push_back($sformatf("%s.c%0d", nm, i + 1));
        end
        stage.delete();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (noise && i < n) begin
                s = 1'b1;
                instr = 16'hE000;
            end else begin
                s = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", expq.size());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        s = 1'b0;
        instr = 16'h0000;
        #1 rst_n = 1'b0;
        #1;
        chk("rst.w", {15'd0, w}, 16'd1);
        chk("rst.write", {15'd0, write}, 16'd0);
        chk("rst.loads", {12'd0, loada, loadb, loadc, loads}, 16'd0);
        chk("rst.sx", sximm8, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // MOV R0,#7 on the first edge after reset release
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0007));
        stage.push_back(S(0, 0, 0, 8'b1000_0001, 2'b00, 2'b00, 16'h0007));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0007));
        issue(16'hD007, "movi7", 0, 1);

        // MOV R1,#-2 back to back
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'hFFFE));
        stage.push_back(S(0, 0, 1, 8'b1000_0001, 2'b00, 2'b00, 16'hFFFE));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'hFFFE));
        issue(16'hD1FE, "movim2", 0, 0);

        // ADD R2,R1,R0 LSL1
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0048));
        stage.push_back(S(0, 1, 0, 8'b0100_0000, 2'b00, 2'b00, 16'h0048));
        stage.push_back(S(0, 0, 0, 8'b0010_0000, 2'b00, 2'b00, 16'h0048));
        stage.push_back(S(0, 0, 0, 8'b0001_0000, 2'b01, 2'b00, 16'h0048));
        stage.push_back(S(0, 0, 2, 8'b1000_0000, 2'b00, 2'b00, 16'h0048));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0048));
        issue(16'hA148, "add", 0, 0);

        // CMP R1,R0
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0000));
        stage.push_back(S(0, 1, 0, 8'b0100_0000, 2'b00, 2'b00, 16'h0000));
        stage.push_back(S(0, 0, 0, 8'b0010_0000, 2'b00, 2'b00, 16'h0000));
        stage.push_back(S(0, 0, 0, 8'b0001_1000, 2'b00, 2'b01, 16'h0000));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0000));
        issue(16'hA900, "cmp", 0, 0);

        // MOV R3,R3 LSL1
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h006B));
        stage.push_back(S(0, 3, 0, 8'b0010_0000, 2'b00, 2'b00, 16'h006B));
        stage.push_back(S(0, 0, 0, 8'b0001_0100, 2'b01, 2'b00, 16'h006B));
        stage.push_back(S(0, 0, 3, 8'b1000_0000, 2'b00, 2'b00, 16'h006B));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h006B));
        issue(16'hC06B, "movr", 0, 0);

        // MVN R5,R2
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'hFFA2));
        stage.push_back(S(0, 2, 0, 8'b0010_0000, 2'b00, 2'b00, 16'hFFA2));
        stage.push_back(S(0, 0, 0, 8'b0001_0100, 2'b00, 2'b11, 16'hFFA2));
        stage.push_back(S(0, 0, 5, 8'b1000_0000, 2'b00, 2'b00, 16'hFFA2));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'hFFA2));
        issue(16'hB8A2, "mvn", 0, 0);

        // AND R4,R2,R1 LSR with s pulses and instr=0xE000 while busy
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'hFF91));
        stage.push_back(S(0, 2, 0, 8'b0100_0000, 2'b00, 2'b00, 16'hFF91));
        stage.push_back(S(0, 1, 0, 8'b0010_0000, 2'b00, 2'b00, 16'hFF91));
        stage.push_back(S(0, 0, 0, 8'b0001_0000, 2'b10, 2'b10, 16'hFF91));
        stage.push_back(S(0, 0, 4, 8'b1000_0000, 2'b00, 2'b00, 16'hFF91));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'hFF91));
        issue(16'hB291, "and_noise", 1, 0);

        // unsupported encodings: one busy cycle, nothing asserted
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0000));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0000));
        issue(16'hE000, "bad_e000", 0, 0);
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0034));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0034));
        issue(16'h1234, "bad_1234", 0, 0);
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0005));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0005));
        issue(16'hC805, "bad_c805", 0, 0);
        drain();

        // reset in the middle of an ADD, during GET_B
        @(negedge clk);
        #1 mon_en = 1'b0;
        @(negedge clk);
        instr = 16'hA148;
        s = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("getb.loadb", {15'd0, loadb}, 16'd1);
        chk("getb.readnum", {13'd0, readnum}, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("mid.w", {15'd0, w}, 16'd1);
        chk("mid.loadb", {15'd0, loadb}, 16'd0);
        chk("mid.write", {15'd0, write}, 16'd0);
        chk("mid.sx", sximm8, 16'h0000);
        #4 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("post.sx", sximm8, 16'h0000);

        // fresh s required, then normal operation resumes
        stage.push_back(S(0, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0007));
        stage.push_back(S(0, 0, 0, 8'b1000_0001, 2'b00, 2'b00, 16'h0007));
        stage.push_back(S(1, 0, 0, 8'b0000_0000, 2'b00, 2'b00, 16'h0007));
        issue(16'hD007, "movi7_again", 0, 0);
        drain();
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
